// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state type, access size codes and load lane extraction for the LSU
// Contents:
//   lsu_state_e   : access sequencer states (IDLE/RD/WR/DONE)
//   SIZE_B/H/W    : req_size encodings; 2'b11 is handled like SIZE_W
//   lane_extract  : pick the byte/halfword lane out of a RAM word and extend it
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Halfword lane selection only looks at off[1], so an odd halfword address
  // reads the enclosing aligned halfword.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SIZE_H:  res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_wishbone_if.sv
// rtl/lsu_wishbone_if.sv - request/response and Wishbone RAM signals of the load/store unit
// Signals:
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata : core request
//   rsp_valid/rsp_rdata/rsp_err                                       : one-cycle completion
//   STB_O/WE_O/ADR_O/DAT_O/DAT_I                                      : Wishbone data RAM port
// Modports:
//   master : the LSU (drives ready, responses and the Wishbone strobes)
//   slave  : the environment (core request side plus the RAM)
interface lsu_wishbone_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        STB_O;
  logic        WE_O;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, DAT_I,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, STB_O, WE_O, ADR_O, DAT_O
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, DAT_I,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, STB_O, WE_O, ADR_O, DAT_O
  );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational lane extraction for loads and lane merge for sub-word stores
// Ports:
//   word_i   : current RAM word (DAT_I during the read strobe)
//   off_i    : captured addr[1:0]
//   size_i   : captured req_size
//   uns_i    : captured req_unsigned
//   wdata_i  : captured store data, right-aligned
//   load_o   : extended load result
//   merged_o : RAM word with the store lane replaced (wdata_i itself for word stores)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  assign load_o = lane_extract(word_i, off_i, size_i, uns_i);

  always_comb begin
    merged_o = word_i;
    case (size_i)
      SIZE_B: begin
        case (off_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SIZE_H: begin
        if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else          merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_wishbone.sv
// rtl/lsu_wishbone.sv - load/store unit turning core requests into single-cycle Wishbone RAM strobes
// Parameters:
//   BASE_ADDR : subtracted (mod 2^32) from req_addr to form ADR_O
// Ports:
//   CLK_I : clock, rising edge
//   RST_I : synchronous active-high reset
//   bus   : lsu_wishbone_if.master (request, response and Wishbone signals)
// Build option:
//   LSU_ALIGN_CHECK_EN : when defined, misaligned halfword/word accesses complete with rsp_err=1
//                        and no RAM access; when undefined rsp_err is always 0
module lsu_wishbone
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  lsu_wishbone_if.master bus
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        stb_q, stb_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_o_q, dat_o_d;

  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        req_misaligned;

  lsu_lane_align u_lane_align (
    .word_i   (bus.DAT_I),
    .off_i    (off_q),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merged_o (merged_word)
  );

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    case (bus.req_size)
      SIZE_B:  req_misaligned = 1'b0;
      SIZE_H:  req_misaligned = bus.req_addr[0];
      default: req_misaligned = |bus.req_addr[1:0];
    endcase
  end
`else
  assign req_misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    adr_d       = adr_q;
    stb_d       = 1'b0;
    wb_we_d     = 1'b0;
    dat_o_d     = 32'd0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          off_d   = bus.req_addr[1:0];
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          adr_d   = (bus.req_addr - BASE_ADDR) & 32'hFFFF_FFFC;
          if (req_misaligned) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (bus.req_we && bus.req_size[1]) begin
            // size[1] covers both word and the reserved encoding
            state_d = WR;
            stb_d   = 1'b1;
            wb_we_d = 1'b1;
            dat_o_d = bus.req_wdata;
          end else begin
            state_d = RD;
            stb_d   = 1'b1;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d = WR;
          stb_d   = 1'b1;
          wb_we_d = 1'b1;
          dat_o_d = merged_word;
        end else begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
      end
      WR: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      off_q       <= 2'd0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      stb_q       <= 1'b0;
      wb_we_q     <= 1'b0;
      adr_q       <= 32'd0;
      dat_o_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      stb_q       <= stb_d;
      wb_we_q     <= wb_we_d;
      adr_q       <= adr_d;
      dat_o_q     <= dat_o_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.STB_O     = stb_q;
  assign bus.WE_O      = wb_we_q;
  assign bus.ADR_O     = adr_q;
  assign bus.DAT_O     = dat_o_q;

endmodule

// File: tb/tb_lsu_wishbone.sv
// tb/tb_lsu_wishbone.sv - self-checking bench for lsu_wishbone against a byte-level memory model
`timescale 1ns/1ps
module tb_lsu_wishbone;

  logic CLK_I = 1'b0;
  logic RST_I;
  always #5 CLK_I = ~CLK_I;

  lsu_wishbone_if bus();

  lsu_wishbone #(.BASE_ADDR(32'h0000_0000)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .bus   (bus)
  );

  // Wishbone RAM: 256 words, combinational read, write on strobe edge (not during reset)
  logic [31:0] ram [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  assign bus.DAT_I = ram[bus.ADR_O[9:2]];

  always @(posedge CLK_I) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (!RST_I && bus.STB_O && bus.WE_O) ram[bus.ADR_O[9:2]] <= bus.DAT_O;
  end

  // Reference memory kept as little-endian bytes
  logic [7:0] ref_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  function automatic int ref_nbytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic ref_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
    return (addr % ref_nbytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_lat(input logic we, input logic [1:0] size, input logic [31:0] addr);
    if (ref_mis(size, addr)) return 1;
    if (!we) return 2;
    if (ref_nbytes(size) == 4) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    int n;
    int a;
    logic [31:0] v;
    n = ref_nbytes(size);
    a = (int'(addr[9:0]) / n) * n;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[a + i]) << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic void ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    int a;
    n = ref_nbytes(size);
    a = (int'(addr[9:0]) / n) * n;
    for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8 * i +: 8];
  endfunction

  // Drives one request and records what the DUT did until its response (or a bound).
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int n_rd, output int n_wr,
                       output logic [31:0] adr_seen, output logic [31:0] dat_seen);
    int w;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    w = 0;
    while (!bus.req_ready && w < 10) begin
      @(posedge CLK_I); #1;
      w++;
    end
    if (!bus.req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL issue_ready_timeout: req_ready=%0b required 1", bus.req_ready);
    end
    @(posedge CLK_I); #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    lat = -1; n_rd = 0; n_wr = 0; adr_seen = 32'd0; dat_seen = 32'd0;
    rdata = 32'd0; err = 1'b0;
    for (int cyc = 1; cyc <= 6 && lat < 0; cyc++) begin
      if (bus.STB_O && !bus.WE_O) begin n_rd++; adr_seen = bus.ADR_O; end
      if (bus.STB_O && bus.WE_O)  begin n_wr++; adr_seen = bus.ADR_O; dat_seen = bus.DAT_O; end
      if (bus.rsp_valid) begin
        lat = cyc; rdata = bus.rsp_rdata; err = bus.rsp_err;
      end else begin
        @(posedge CLK_I); #1;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h required 0", bus.rsp_rdata); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b required 0", bus.rsp_err); end
    n_checks++; if (bus.STB_O !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b required 0", bus.STB_O); end
    n_checks++; if (bus.WE_O !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b required 0", bus.WE_O); end
    n_checks++; if (bus.ADR_O !== 32'd0) begin n_fail++; $display("FAIL rst_adr: got %h required 0", bus.ADR_O); end
    n_checks++; if (bus.DAT_O !== 32'd0) begin n_fail++; $display("FAIL rst_dat: got %h required 0", bus.DAT_O); end
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd, adr, dat; logic er; int lat, nr, nw;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, nr, nw, adr, dat);
    ref_store(2'd2, 32'h10, 32'hDEAD_BEEF);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d required 2", lat); end
    n_checks++; if (nr !== 0 || nw !== 1) begin n_fail++; $display("FAIL sw_strobes: got rd=%0d wr=%0d required rd=0 wr=1", nr, nw); end
    n_checks++; if (adr !== 32'h10) begin n_fail++; $display("FAIL sw_adr: got %h required 00000010", adr); end
    n_checks++; if (dat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_dat: got %h required deadbeef", dat); end
    n_checks++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL sw_rsp: got rdata=%h err=%b required 0/0", rd, er); end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nr, nw, adr, dat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d required 2", lat); end
    n_checks++; if (nr !== 1 || nw !== 0) begin n_fail++; $display("FAIL lw_strobes: got rd=%0d wr=%0d required rd=1 wr=0", nr, nw); end
    n_checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_rsp: got rdata=%h err=%b required deadbeef/0", rd, er); end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd, adr, dat; logic er; int lat, nr, nw;
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h1234_565A, rd, er, lat, nr, nw, adr, dat);
    ref_store(2'd0, 32'h12, 32'h1234_565A);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d required 3", lat); end
    n_checks++; if (nr !== 1 || nw !== 1) begin n_fail++; $display("FAIL sb_strobes: got rd=%0d wr=%0d required rd=1 wr=1", nr, nw); end
    n_checks++; if (dat !== 32'hDE5A_BEEF) begin n_fail++; $display("FAIL sb_merged: got %h required de5abeef", dat); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] rd, adr, dat; logic er; int lat, nr, nw;
    logic [31:0] t_addr [4];
    logic [1:0]  t_size [4];
    logic        t_uns  [4];
    logic [31:0] t_exp  [4];
    t_addr[0] = 32'h13; t_size[0] = 2'd0; t_uns[0] = 1'b0; t_exp[0] = 32'hFFFF_FFDE;
    t_addr[1] = 32'h13; t_size[1] = 2'd0; t_uns[1] = 1'b1; t_exp[1] = 32'h0000_00DE;
    t_addr[2] = 32'h12; t_size[2] = 2'd1; t_uns[2] = 1'b0; t_exp[2] = 32'hFFFF_DE5A;
    t_addr[3] = 32'h10; t_size[3] = 2'd1; t_uns[3] = 1'b1; t_exp[3] = 32'h0000_BEEF;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, rd, er, lat, nr, nw, adr, dat);
      n_checks++;
      if (rd !== t_exp[i] || lat !== 2) begin
        n_fail++; $display("FAIL ext_load_%0d: got rdata=%h lat=%0d required %h lat=2", i, rd, lat, t_exp[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, adr, dat; logic er; int lat, nr, nw;
    issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, rd, er, lat, nr, nw, adr, dat);
`ifdef LSU_ALIGN_CHECK_EN
    n_checks++; if (lat !== 1 || er !== 1'b1) begin n_fail++; $display("FAIL mis_lw: got lat=%0d err=%b required lat=1 err=1", lat, er); end
    n_checks++; if (nr + nw !== 0) begin n_fail++; $display("FAIL mis_lw_strobe: got %0d strobes required 0", nr + nw); end
`else
    n_checks++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL mis_lw: got lat=%0d err=%b required lat=2 err=0", lat, er); end
    n_checks++; if (rd !== 32'hDE5A_BEEF || adr !== 32'h10) begin n_fail++; $display("FAIL mis_lw_data: got %h @%h required de5abeef @00000010", rd, adr); end
`endif
  endtask

  task automatic test_reset_mid_access();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h0000_7777;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_before: got %b required 1", bus.req_ready); end
    @(posedge CLK_I); #1;
    bus.req_valid = 1'b0;
    n_checks++; if (bus.STB_O !== 1'b1 || bus.WE_O !== 1'b0) begin n_fail++; $display("FAIL rm_read_strobe: got stb=%b we=%b required 1/0", bus.STB_O, bus.WE_O); end
    @(posedge CLK_I); #1;
    n_checks++; if (bus.STB_O !== 1'b1 || bus.WE_O !== 1'b1) begin n_fail++; $display("FAIL rm_write_strobe: got stb=%b we=%b required 1/1", bus.STB_O, bus.WE_O); end
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.STB_O !== 1'b0 || bus.WE_O !== 1'b0 || bus.ADR_O !== 32'd0 ||
        bus.DAT_O !== 32'd0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_outputs: got rsp=%b stb=%b we=%b adr=%h dat=%h rdata=%h required all 0",
               bus.rsp_valid, bus.STB_O, bus.WE_O, bus.ADR_O, bus.DAT_O, bus.rsp_rdata);
    end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b required 1", bus.req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK_I); #1;
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp_%0d: got %b required 0", i, bus.rsp_valid); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, adr, dat, a, wd, exp_rd; logic er, we, uns, mis; logic [1:0] sz; int lat, nr, nw, xl;
    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      a = $urandom_range(0, 1023); wd = $urandom;
      mis = ref_mis(sz, a);
      xl = ref_lat(we, sz, a);
      exp_rd = (we || mis) ? 32'd0 : ref_load(sz, uns, a);
      issue(we, sz, uns, a, wd, rd, er, lat, nr, nw, adr, dat);
      if (!mis && we) ref_store(sz, a, wd);
      n_checks++; if (lat !== xl) begin n_fail++; $display("FAIL rnd_lat[%0d]: got %0d required %0d", k, lat, xl); end
      n_checks++; if (rd !== exp_rd || er !== mis) begin n_fail++; $display("FAIL rnd_rsp[%0d]: got %h/%b required %h/%b", k, rd, er, exp_rd, mis); end
      n_checks++;
      if (nr !== ((mis || (we && sz[1])) ? 0 : 1) || nw !== ((!mis && we) ? 1 : 0)) begin
        n_fail++; $display("FAIL rnd_strobes[%0d]: got rd=%0d wr=%0d", k, nr, nw);
      end
      if (!mis) begin
        n_checks++; if (adr !== (a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL rnd_adr[%0d]: got %h required %h", k, adr, a & 32'hFFFF_FFFC); end
      end
      @(posedge CLK_I); #1;
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_pulse[%0d]: got rsp=%b ready=%b required 0/1", k, bus.rsp_valid, bus.req_ready); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t e;
    int acc, nrsp;
    logic we, uns, mis, exp_rsp; logic [1:0] sz; logic [31:0] a, wd;
    acc = 0; nrsp = 0;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (acc >= 16) bus.req_valid = 1'b0;
      we = 1'(acc % 2); sz = 2'($urandom); uns = 1'($urandom);
      a = $urandom_range(0, 1023); wd = $urandom;
      bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
      n_checks++; if (bus.req_ready !== (q.size() == 0)) begin n_fail++; $display("FAIL b2b_ready[c%0d]: got %b required %b", c, bus.req_ready, q.size() == 0); end
      exp_rsp = (q.size() != 0) && (q[0].due == c);
      n_checks++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL b2b_rsp_valid[c%0d]: got %b required %b", c, bus.rsp_valid, exp_rsp); end
      if (exp_rsp) begin
        e = q.pop_front();
        if (bus.rsp_valid) begin
          nrsp++;
          n_checks++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin n_fail++; $display("FAIL b2b_rsp[c%0d]: got %h/%b required %h/%b", c, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
        end
      end else if (bus.rsp_valid) begin
        nrsp++;
      end
      if (bus.req_valid && bus.req_ready) begin
        mis = ref_mis(sz, a);
        e.due = c + ref_lat(we, sz, a);
        e.err = mis;
        e.rdata = (we || mis) ? 32'd0 : ref_load(sz, uns, a);
        if (!mis && we) ref_store(sz, a, wd);
        q.push_back(e);
        acc++;
      end
      @(posedge CLK_I); #1;
    end
    bus.req_valid = 1'b0;
    n_checks++; if (acc !== 16) begin n_fail++; $display("FAIL b2b_accepted: got %0d required 16", acc); end
    n_checks++; if (nrsp !== 16 || q.size() !== 0) begin n_fail++; $display("FAIL b2b_responses: got %0d pending=%0d required 16/0", nrsp, q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    RST_I = 1'b1;
    pl_en = 1'b0; pl_idx = 8'd0; pl_data = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    @(posedge CLK_I); #1;
    pl_en = 1'b1;
    for (int w = 0; w < 256; w++) begin
      pl_idx = 8'(w); pl_data = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4 * w + b] = pl_data[8 * b +: 8];
      @(posedge CLK_I); #1;
    end
    pl_en = 1'b0;
    test_reset();
    RST_I = 1'b0;
    @(posedge CLK_I); #1;
    test_word_store_load();
    test_byte_store();
    test_sign_ext();
    test_misaligned();
    @(posedge CLK_I); #1;
    test_reset_mid_access();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
